// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle MUL/MLA sequencer.
// Contents:
//   - ALU command encodings used on the shared execute-stage ALU.
//   - Bit positions inside the {N,Z,C,V} status nibble.
//   - Sequencer state type.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_MVN = 4'b1001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-and-add MUL/MLA controller sharing the EX-stage ALU.
// While idle the ALU ports pass the EX-stage operands straight through; once a
// multiply starts, the sequencer owns the ALU (ADD of acc + mcand each
// iteration), stalls the pipeline, and presents the low WIDTH product bits
// together with an NZCV update in a single DONE cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, accumulate        begin a multiply (IDLE only); 1 = MLA
//   setFlags, statusIn       S bit; current {N,Z,C,V}
//   opA, opB, opC            multiplicand, multiplier, accumulate operand
//   exeVal1/2, exeCommand,
//   exeCarry                 EX-stage ALU request, passed through when idle
//   aluVal1/2, aluCommand,
//   aluCarry, aluResult      shared ALU interface
//   stall, busy, done        pipeline freeze, not-idle, result-valid pulse
//   result, statusOut,
//   statusWrite              product, flags to write, flag write enable
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             accumulate,
  input  logic             setFlags,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opC,
  input  logic [3:0]       statusIn,
  input  logic [WIDTH-1:0] exeVal1,
  input  logic [WIDTH-1:0] exeVal2,
  input  logic [3:0]       exeCommand,
  input  logic             exeCarry,
  output logic [WIDTH-1:0] aluVal1,
  output logic [WIDTH-1:0] aluVal2,
  output logic [3:0]       aluCommand,
  output logic             aluCarry,
  input  logic [WIDTH-1:0] aluResult,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut,
  output logic             statusWrite
);

  // Iteration count at which the multiply is complete (6-bit counter).
  localparam logic [5:0] CNT_LAST = 6'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [5:0]       cnt;
  logic             s_latched;

  logic [5:0]       cnt_inc;
  logic [WIDTH-1:0] mplier_shr;
  logic             iter_last;
  logic [3:0]       flags_done;

  assign cnt_inc    = cnt + 6'd1;
  assign mplier_shr = mplier >> 1;
  // Exit is decided on the post-update values so opB = 0 still spends one
  // ITER cycle and the highest set bit of opB is the last one processed.
  assign iter_last  = (cnt_inc == CNT_LAST) ||
                      (EARLY_EXIT && (mplier_shr == '0));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_ITER;
      ST_ITER: if (iter_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Multiply datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      s_latched <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand     <= opA;
            mplier    <= opB;
            acc       <= accumulate ? opC : '0;
            cnt       <= '0;
            s_latched <= setFlags;
          end
        end
        ST_ITER: begin
          if (mplier[0]) begin
            acc <= aluResult;
          end
          mcand  <= mcand << 1;
          mplier <= mplier_shr;
          cnt    <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  // N and Z come from the product; C and V are carried over from statusIn.
  always_comb begin
    flags_done         = statusIn;
    flags_done[FLAG_N] = acc[WIDTH-1];
    flags_done[FLAG_Z] = (acc == '0);
  end

  assign result = acc;

  // Output logic
  always_comb begin
    aluVal1     = exeVal1;
    aluVal2     = exeVal2;
    aluCommand  = exeCommand;
    aluCarry    = exeCarry;
    stall       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    statusOut   = '0;
    statusWrite = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = start;
      end
      ST_ITER: begin
        aluVal1    = acc;
        aluVal2    = mcand;
        aluCommand = ALU_ADD;
        aluCarry   = 1'b0;
        stall      = 1'b1;
        busy       = 1'b1;
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        statusOut   = flags_done;
        statusWrite = s_latched;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer. A behavioural ALU closes the loop on
// the shared-ALU ports; expected products come from plain 64-bit arithmetic.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, accumulate, setFlags;
  logic [31:0] opA, opB, opC;
  logic [3:0]  statusIn;
  logic [31:0] exeVal1, exeVal2;
  logic [3:0]  exeCommand;
  logic        exeCarry;
  logic [31:0] aluVal1, aluVal2, aluResult;
  logic [3:0]  aluCommand;
  logic        aluCarry;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [3:0]  statusOut;
  logic        statusWrite;

  // second instance without early exit
  logic        f_start;
  logic [31:0] f_opA, f_opB;
  logic [31:0] f_aluVal1, f_aluVal2, f_aluResult;
  logic [3:0]  f_aluCommand;
  logic        f_aluCarry;
  logic        f_stall, f_busy, f_done;
  logic [31:0] f_result;
  logic [3:0]  f_statusOut;
  logic        f_statusWrite;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
    .setFlags(setFlags), .opA(opA), .opB(opB), .opC(opC),
    .statusIn(statusIn), .exeVal1(exeVal1), .exeVal2(exeVal2),
    .exeCommand(exeCommand), .exeCarry(exeCarry),
    .aluVal1(aluVal1), .aluVal2(aluVal2), .aluCommand(aluCommand),
    .aluCarry(aluCarry), .aluResult(aluResult),
    .stall(stall), .busy(busy), .done(done), .result(result),
    .statusOut(statusOut), .statusWrite(statusWrite)
  );

  alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(f_start), .accumulate(1'b0),
    .setFlags(1'b1), .opA(f_opA), .opB(f_opB), .opC(32'h0),
    .statusIn(4'b0000), .exeVal1(32'h0), .exeVal2(32'h0),
    .exeCommand(4'b0000), .exeCarry(1'b0),
    .aluVal1(f_aluVal1), .aluVal2(f_aluVal2), .aluCommand(f_aluCommand),
    .aluCarry(f_aluCarry), .aluResult(f_aluResult),
    .stall(f_stall), .busy(f_busy), .done(f_done), .result(f_result),
    .statusOut(f_statusOut), .statusWrite(f_statusWrite)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] cmd,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic cin);
    case (cmd)
      4'b0001: return b;
      4'b1001: return ~b;
      4'b0010: return a + b;
      4'b0011: return a + b + {31'b0, cin};
      4'b0100: return a - b;
      4'b0101: return a - b - {31'b0, ~cin};
      4'b0110: return a & b;
      4'b0111: return a | b;
      4'b1000: return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb aluResult   = alu_f(aluCommand, aluVal1, aluVal2, aluCarry);
  always_comb f_aluResult = alu_f(f_aluCommand, f_aluVal1, f_aluVal2, f_aluCarry);

  typedef struct {
    logic [31:0] res;
    logic [3:0]  st;
    logic        sw;
    int          n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   iter_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
    else passes++;
  endtask

  // Reference: ARM MUL/MLA truncated product; ITER count = index of the
  // multiplier's highest set bit + 1, at least one.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic accum,
                                 input logic s, input logic [3:0] status);
    exp_t        e;
    logic [63:0] full;
    full  = {32'h0, a} * {32'h0, b} + (accum ? {32'h0, c} : 64'h0);
    e.res = full[31:0];
    e.st  = {e.res[31], (e.res == 32'h0), status[1], status[0]};
    e.sw  = s;
    e.n   = 1;
    for (int i = 0; i < 32; i++) if (b[i]) e.n = i + 1;
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      iter_cnt = 0;
    end else begin
      if (busy && !done) begin
        iter_cnt++;
        check("stall_iter", {63'h0, stall}, 64'h1);
        check("alu_cmd_iter", {59'h0, aluCommand, aluCarry}, {59'h0, 4'b0010, 1'b0});
      end else begin
        check("alu_passthru", {aluVal1, aluVal2}, {exeVal1, exeVal2});
        check("alu_passthru_cmd", {59'h0, aluCommand, aluCarry}, {59'h0, exeCommand, exeCarry});
      end
      if (done) begin
        exp_t e;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done=1, expected no pending operation");
        end else begin
          e = q.pop_front();
          check("result", {32'h0, result}, {32'h0, e.res});
          check("statusOut", {60'h0, statusOut}, {60'h0, e.st});
          check("statusWrite", {63'h0, statusWrite}, {63'h0, e.sw});
          check("iter_cycles", 64'(iter_cnt), 64'(e.n));
          check("stall_done", {63'h0, stall}, 64'h0);
        end
        iter_cnt = 0;
      end
      if (!busy) iter_cnt = 0;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic accum,
                       input logic s, input logic [3:0] status,
                       input bit hold);
    bit got;
    got = 0;
    @(posedge clk); #2;
    opA = a; opB = b; opC = c; accumulate = accum; setFlags = s;
    statusIn = status;
    exeVal1 = $urandom; exeVal2 = $urandom;
    exeCommand = 4'($urandom); exeCarry = 1'($urandom);
    start = 1'b1;
    #1;
    check("stall_start", {62'h0, stall, busy}, {62'h0, 1'b1, 1'b0});
    q.push_back(model(a, b, c, accum, s, status));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (!hold) start = 1'b0;
      if (done) begin
        got = 1;
        start = 1'b0;
        break;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected done");
    end
    @(posedge clk); #2;
    if (hold) check("no_restart", {63'h0, busy}, 64'h0);
  endtask

  task automatic full_run(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] req_res, input logic [3:0] req_st);
    int n;
    bit got;
    n = 0;
    got = 0;
    @(posedge clk); #2;
    f_opA = a; f_opB = b; f_start = 1'b1;
    @(posedge clk); #2;
    f_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (f_done) begin
        got = 1;
        break;
      end
      if (f_busy) n++;
      @(posedge clk); #2;
    end
    if (!got) begin
      checks++;
      $display("FAIL full_timeout: got no done in 40 cycles, expected done");
    end else begin
      check("full_iter_cycles", 64'(n), 64'd32);
      check("full_result", {32'h0, f_result}, {32'h0, req_res});
      check("full_status", {59'h0, f_statusOut, f_statusWrite}, {59'h0, req_st, 1'b1});
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; accumulate = 1'b0; setFlags = 1'b0;
    opA = '0; opB = '0; opC = '0; statusIn = '0;
    exeVal1 = 32'd5; exeVal2 = 32'd3; exeCommand = 4'b0100; exeCarry = 1'b0;
    f_start = 1'b0; f_opA = '0; f_opB = '0;
    #1;
    check("reset_ctrl", {60'h0, stall, busy, done, statusWrite}, 64'h0);
    check("reset_data", {28'h0, result, statusOut}, 64'h0);
    #20;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("idle_alu_ops", {aluVal1, aluVal2}, {32'd5, 32'd3});
    check("idle_alu_cmd", {59'h0, aluCommand, aluCarry}, {59'h0, 4'b0100, 1'b0});
    check("idle_ctrl", {61'h0, stall, busy, done}, 64'h0);

    // directed cases
    issue(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b0011, 1'b0);
    issue(32'd3, 32'd5, 32'd10, 1'b1, 1'b0, 4'b0000, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
    issue(32'h1234, 32'd0, 32'd0, 1'b0, 1'b1, 4'b1010, 1'b0);
    issue(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0001, 1'b0);
    issue(32'd9, 32'd11, 32'd4, 1'b1, 1'b1, 4'b0110, 1'b1);
    issue(32'd0, 32'd0, 32'd77, 1'b1, 1'b1, 4'b0000, 1'b0);

    // reset during ITER cycle 10
    @(posedge clk); #2;
    opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF; accumulate = 1'b0; setFlags = 1'b1;
    exeVal1 = 32'hDEAD_BEEF; exeVal2 = 32'h0BAD_F00D; exeCommand = 4'b0111; exeCarry = 1'b1;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("pre_reset_busy", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", {60'h0, stall, busy, done, statusWrite}, 64'h0);
    check("rst_mid_data", {28'h0, result, statusOut}, 64'h0);
    check("rst_mid_alu", {aluVal1, aluVal2}, {32'hDEAD_BEEF, 32'h0BAD_F00D});
    check("rst_mid_alu_cmd", {59'h0, aluCommand, aluCarry}, {59'h0, 4'b0111, 1'b1});
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    issue(32'd2, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // randomized operations with varied multiplier length
    for (int t = 0; t < 40; t++) begin
      logic [31:0] b;
      int unsigned k;
      k = $urandom_range(0, 32);
      b = $urandom;
      if (k < 32) b = b & ((32'h1 << k) - 32'h1);
      issue($urandom, b, $urandom, 1'($urandom), 1'($urandom), 4'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    // full-length instance
    full_run(32'h8000_0000, 32'd1, 32'h8000_0000, 4'b1000);
    full_run(32'd7, 32'd6, 32'd42, 4'b0000);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
